uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_parity.sv | 15 +
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and FSM state encoding
package uart_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int PRESCALE_W_DEF = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_parity.sv
// rtl/uart_tx_parity.sv - combinational parity bit generator for the transmitter
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              par_typ_i,
    output logic              par_bit_o
);

    // Odd parity makes the total count of ones odd, so it is the inverted XOR.
    assign par_bit_o = par_typ_i ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, data LSB first, optional parity, stop
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic [2:0]            state_q,    state_d;
    logic [PRESCALE_W-1:0] cnt_q,      cnt_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [DATA_W-1:0]     data_q,     data_d;
    logic [DATA_W-1:0]     shreg_q,    shreg_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_typ_q,  par_typ_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  tx_q,       tx_d;
    logic                  busy_q,     busy_d;

    logic [PRESCALE_W-1:0] cell_last;
    logic                  cell_done;
    logic [DATA_W-1:0]     shreg_next;
    logic                  par_bit;

    // Parity is taken from the unshifted latched copy, never from the shifter.
    uart_tx_parity #(
        .DATA_W (DATA_W)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_bit_o (par_bit)
    );

    // A latched prescale of 0 behaves as 1 clk per bit.
    assign cell_last  = (prescale_q == '0) ? '0 : prescale_q - PRESCALE_W'(1);
    assign cell_done  = (cnt_q == cell_last);
    assign shreg_next = shreg_q >> 1;

    // Next-state logic: tx_d is the line level for the cycle after this edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        prescale_d = prescale_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        if (state_q != ST_IDLE) begin
            cnt_d = cell_done ? '0 : cnt_q + PRESCALE_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (DATA_VALID) begin
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    data_d     = P_DATA;
                    shreg_d    = P_DATA;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    prescale_d = prescale;
                    cnt_d      = '0;
                    idx_d      = '0;
                end
            end
            ST_START: begin
                if (cell_done) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (cell_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_next;
                        tx_d    = shreg_next[0];
                    end
                end
            end
            ST_PARITY: begin
                if (cell_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (cell_done) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            prescale_q <= prescale_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int tests;
    int fails;

    uart_tx #(
        .DATA_W     (8),
        .PRESCALE_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single clk, then scrambles the inputs so a
    // design that fails to latch them shows a corrupted frame.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] ps);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        prescale   = ps;
        DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        DATA_VALID = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pen;
        PAR_TYP    = ~ptyp;
        prescale   = ps + 6'd3;
    endtask

    // bits[i] is the expected level of frame cell i; every cycle of every cell is checked.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits, input int n);
        int  busy_cnt;
        logic ok;
        busy_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            ok = 1'b1;
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                if (busy === 1'b1) busy_cnt++;
                if (TX_OUT !== bits[i] || busy !== 1'b1) ok = 1'b0;
            end
            chk($sformatf("%s_cell%0d", tag, i), {31'd0, ok}, 32'd1);
        end
        @(negedge clk);
        chk($sformatf("%s_busy_cycles", tag), busy_cnt, nbits * n);
        chk($sformatf("%s_end_idle", tag), {30'd0, busy, TX_OUT}, 32'd1);
    endtask

    // Independent receiver: finds the start edge, samples each cell mid-bit.
    task automatic rx_frame(input string tag, input int n, input logic pen, input logic ptyp,
                            input logic [7:0] sent);
        int         waited;
        logic [7:0] d;
        logic       perr;
        logic       serr;
        waited = 0;
        d      = 8'h00;
        perr   = 1'b0;
        do begin
            @(negedge clk);
            waited++;
        end while (TX_OUT !== 1'b0 && waited < 200);
        chk({tag, "_start_seen"}, {31'd0, (waited < 200)}, 32'd1);
        repeat ((n - 1) / 2) @(negedge clk);
        chk({tag, "_start_mid"}, {31'd0, TX_OUT}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (n) @(negedge clk);
            d[i] = TX_OUT;
        end
        if (pen) begin
            repeat (n) @(negedge clk);
            perr = (TX_OUT !== (ptyp ? ~^d : ^d));
        end
        repeat (n) @(negedge clk);
        serr = (TX_OUT !== 1'b1);
        chk({tag, "_data"}, {24'd0, d}, {24'd0, sent});
        chk({tag, "_par_err"}, {31'd0, perr}, 32'd0);
        chk({tag, "_stp_err"}, {31'd0, serr}, 32'd0);
        waited = 0;
        while (busy !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd0;

        // Reset state
        #12;
        chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", {30'd0, busy, TX_OUT}, 32'd1);

        // 0x09 odd parity, 8 clk/bit: 0,1,0,0,1,0,0,0,0,1,1
        send(8'h09, 1'b1, 1'b1, 6'd8);
        check_frame("f09_odd_p8", 16'h0612, 11, 8);

        // 0x09 even parity, 16 clk/bit: parity cell is 0
        send(8'h09, 1'b1, 1'b0, 6'd16);
        check_frame("f09_even_p16", 16'h0412, 11, 16);

        // 0xA5 no parity, 8 clk/bit: 0,1,0,1,0,0,1,0,1,1
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        check_frame("fA5_nopar_p8", 16'h034A, 10, 8);

        // Second request 20 clk into a frame must be ignored
        send(8'h09, 1'b1, 1'b1, 6'd8);
        fork
            check_frame("f09_ignore", 16'h0612, 11, 8);
            begin
                repeat (20) @(posedge clk);
                #1;
                P_DATA     = 8'hFF;
                DATA_VALID = 1'b1;
                @(posedge clk);
                #1;
                DATA_VALID = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("ignore_no_second_frame", {30'd0, busy, TX_OUT}, 32'd1);

        // Reset during frame cell 3 aborts immediately
        send(8'h09, 1'b1, 1'b1, 6'd8);
        repeat (3 * 8 + 3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx", {31'd0, TX_OUT}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_held_idle", {30'd0, busy, TX_OUT}, 32'd1);
        send(8'h09, 1'b1, 1'b1, 6'd8);
        check_frame("f09_after_rst", 16'h0612, 11, 8);

        // Loopback through the bench receiver over parity/prescale combinations
        send(8'h3C, 1'b1, 1'b1, 6'd8);
        rx_frame("lb0", 8, 1'b1, 1'b1, 8'h3C);
        send(8'hC3, 1'b1, 1'b0, 6'd8);
        rx_frame("lb1", 8, 1'b1, 1'b0, 8'hC3);
        send(8'h5A, 1'b0, 1'b0, 6'd8);
        rx_frame("lb2", 8, 1'b0, 1'b0, 8'h5A);
        send(8'h81, 1'b1, 1'b1, 6'd1);
        rx_frame("lb3", 1, 1'b1, 1'b1, 8'h81);
        send(8'h7E, 1'b1, 1'b0, 6'd0);
        rx_frame("lb4", 1, 1'b1, 1'b0, 8'h7E);
        send(8'hE7, 1'b0, 1'b1, 6'd3);
        rx_frame("lb5", 3, 1'b0, 1'b1, 8'hE7);
        send(8'h01, 1'b1, 1'b1, 6'd5);
        rx_frame("lb6", 5, 1'b1, 1'b1, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
